// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction-fetch front end.
//   - fetch_entry_t : one prefetch-queue entry, {pc, ins}, at the core's native
//                     32-bit width.
//   - RV_NOP        : canonical RV32I no-op (addi x0,x0,0), used as fill data.
//   - BYTE_EN_WORD  : byte-enable pattern for a full-word instruction read.
//   - word_align    : clears the two low address bits of a 32-bit address.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_IW = 32;

  localparam logic [31:0] RV_NOP       = 32'h0000_0013;
  localparam logic [3:0]  BYTE_EN_WORD = 4'b1111;

  typedef struct packed {
    logic [FETCH_IW-1:0] pc;
    logic [FETCH_IW-1:0] ins;
  } fetch_entry_t;

  function automatic logic [FETCH_IW-1:0] word_align(input logic [FETCH_IW-1:0] addr);
    return addr & ~(FETCH_IW'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Circular buffer holding fetched {pc, ins} words between the instruction
//   memory and decode. Entries leave strictly in arrival order. The head word
//   reads as zero while the buffer is empty so that nothing stale is shown.
//
//   Parameters
//     DEPTH : number of entries, power of two, >= 2
//     W     : entry width in bits
//   Ports
//     clk, reset : clock, synchronous active-high reset
//     push, din  : write din at the tail (ignored when full without a pop)
//     pop        : drop the head entry (ignored when empty)
//     flush      : discard all entries; wins over push and pop
//     head       : current head entry, zero when empty
//     count      : number of valid entries, 0..DEPTH
//     full/empty : occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees the head slot in the same cycle, so a push into a full
  // buffer is legal only together with a pop.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // NOTE: storage carries no reset; validity is tracked by count/pointers,
  // which keeps the array as plain RAM and never exposes unwritten slots.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end for the pipelined RV32I core. Issues one
//   sequential word read per cycle while queue credit allows, buffers the
//   returned words with their addresses, and hands them to decode under
//   valid/ready flow control. A redirect flushes queued and in-flight fetches
//   and restarts fetch at the (word-aligned) target on the next cycle.
//
//   Parameters
//     IW       : instruction / address width
//     DEPTH    : prefetch queue entries, power of two, >= 2
//     RESET_PC : first fetch address after reset
//   Ports
//     clk, reset     : clock, synchronous active-high reset
//     o_pc_addr      : registered instruction-memory word address
//     o_pc_rd        : registered read strobe; data returns one cycle later
//     o_pc_byte_en   : 4'b1111 while o_pc_rd, else 0
//     i_pc_rddata    : read data, valid the cycle after o_pc_rd
//     o_ins_valid    : queue head valid (suppressed during a redirect)
//     o_ins          : head instruction
//     o_ins_pc       : head instruction address
//     i_ins_ready    : decode accepts the head this cycle
//     i_redirect     : flush and refetch from i_redirect_pc
//     i_redirect_pc  : redirect target, low two bits ignored
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int            IW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [IW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [IW-1:0] o_pc_addr,
  output logic          o_pc_rd,
  output logic [3:0]    o_pc_byte_en,
  input  logic [IW-1:0] i_pc_rddata,
  output logic          o_ins_valid,
  output logic [IW-1:0] o_ins,
  output logic [IW-1:0] o_ins_pc,
  input  logic          i_ins_ready,
  input  logic          i_redirect,
  input  logic [IW-1:0] i_redirect_pc
);

  import fetch_pkg::*;

  localparam int CW  = $clog2(DEPTH) + 1;  // width of the queue count
  localparam int ECW = CW + 1;             // room for count + outstanding + 1

  // Fetch address generator and response tracking.
  logic [IW-1:0]  fetch_pc;      // address of the next sequential issue
  logic           resp_valid;    // a response is arriving this cycle
  logic [IW-1:0]  resp_pc;       // address of the arriving response
  logic           drop;          // arriving response belongs to a flushed stream

  // Queue interface.
  logic           push;
  logic           pop;
  logic [2*IW-1:0] head;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  // Credit and redirect.
  logic [ECW-1:0] entries_next;
  logic [ECW-1:0] demand;
  logic           issue;
  logic [IW-1:0]  redirect_addr;

  // ---------------------------------------------------------------------------
  // Decode-side handshake. The head is hidden during a redirect so decode can
  // never consume an instruction from the path being abandoned.
  // ---------------------------------------------------------------------------
  assign o_ins_valid = !empty && !i_redirect;
  assign pop         = o_ins_valid && i_ins_ready;
  assign {o_ins_pc, o_ins} = head;

  // A returning word is kept unless it was issued before a redirect (drop) or
  // arrives during one. The full guard protects a live entry from being
  // overwritten; the credit rule normally keeps it from ever mattering.
  assign push = resp_valid && !drop && !i_redirect && (!full || pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * IW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({resp_pc, i_pc_rddata}),
    .pop   (pop),
    .flush (i_redirect),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // ---------------------------------------------------------------------------
  // Credit: issue only if, after this edge's push/pop, the queue still has a
  // slot for the read currently in flight plus the one about to be issued.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in this block gets a value before any branch,
  // so no path leaves it unassigned and no latch can be inferred.
  always_comb begin
    entries_next = ECW'(count);
    if (push && !pop) begin
      entries_next = ECW'(count) + ECW'(1);
    end else if (pop && !push) begin
      entries_next = ECW'(count) - ECW'(1);
    end
    demand = entries_next + ECW'(o_pc_rd) + ECW'(1);
    issue  = (demand <= ECW'(DEPTH));
  end

  // Masking (rather than slicing) keeps every target bit in the datapath and
  // clears the byte offset in one step.
  assign redirect_addr = i_redirect_pc & ~(IW'(3));

  // ---------------------------------------------------------------------------
  // Issue registers, fetch PC and response tracking.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      o_pc_rd      <= 1'b0;
      o_pc_byte_en <= 4'b0000;
      o_pc_addr    <= RESET_PC;
      fetch_pc     <= RESET_PC;
      resp_valid   <= 1'b0;
      resp_pc      <= '0;
      drop         <= 1'b0;
    end else begin
      // The read issued this cycle returns next cycle with this address.
      resp_valid <= o_pc_rd;
      resp_pc    <= o_pc_addr;
      // A read issued in the redirect cycle belongs to the old path.
      drop       <= i_redirect && o_pc_rd;

      if (i_redirect) begin
        o_pc_rd      <= 1'b1;
        o_pc_byte_en <= BYTE_EN_WORD;
        o_pc_addr    <= redirect_addr;
        fetch_pc     <= redirect_addr + IW'(4);
      end else if (issue) begin
        o_pc_rd      <= 1'b1;
        o_pc_byte_en <= BYTE_EN_WORD;
        o_pc_addr    <= fetch_pc;
        fetch_pc     <= fetch_pc + IW'(4);
      end else begin
        // No credit: strobe drops, address holds its last value.
        o_pc_rd      <= 1'b0;
        o_pc_byte_en <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue (IW=32, DEPTH=4, RESET_PC=0).
//   A behavioural model (queue of expected entries, outstanding-read record,
//   credit computed from the queue size) predicts every output each cycle;
//   scenario tasks add directed expectations for reset, streaming,
//   backpressure, redirect and reset-while-full.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  import fetch_pkg::*;

  localparam int          IW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk;
  logic          reset;
  logic [IW-1:0] o_pc_addr;
  logic          o_pc_rd;
  logic [3:0]    o_pc_byte_en;
  logic [IW-1:0] i_pc_rddata;
  logic          o_ins_valid;
  logic [IW-1:0] o_ins;
  logic [IW-1:0] o_ins_pc;
  logic          i_ins_ready;
  logic          i_redirect;
  logic [IW-1:0] i_redirect_pc;

  fetch_queue #(
    .IW       (IW),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .o_pc_addr     (o_pc_addr),
    .o_pc_rd       (o_pc_rd),
    .o_pc_byte_en  (o_pc_byte_en),
    .i_pc_rddata   (i_pc_rddata),
    .o_ins_valid   (o_ins_valid),
    .o_ins         (o_ins),
    .o_ins_pc      (o_ins_pc),
    .i_ins_ready   (i_ins_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Memory content model: word at address a is a ^ mem_xor.
  logic [31:0] mem_xor  = 32'h0;
  bit          idle_rand = 1'b0;

  // Behavioural model state.
  fetch_entry_t mq[$];          // expected queue contents, head first
  bit           m_rd;           // expected o_pc_rd
  logic [31:0]  m_addr;         // expected o_pc_addr
  logic [31:0]  m_next_pc;      // next sequential fetch address
  bit           m_arr_valid;    // a wanted response arrives this cycle
  logic [31:0]  m_arr_addr;

  // Observation logs.
  logic [31:0] deliv_pc[$];
  int          deliv_cyc[$];
  logic [31:0] issue_addr[$];

  logic        samp_rd;
  logic [31:0] samp_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ mem_xor;
  endfunction

  // Memory: data for a read seen in cycle n is presented in cycle n+1.
  always @(negedge clk) begin
    samp_rd   = o_pc_rd;
    samp_addr = o_pc_addr;
  end

  always @(posedge clk) begin
    #1;
    if (samp_rd === 1'b1) i_pc_rddata = mem_word(samp_addr);
    else                  i_pc_rddata = idle_rand ? $urandom : RV_NOP;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    mq.delete();
    m_rd        = 1'b0;
    m_addr      = RESET_PC;
    m_next_pc   = RESET_PC;
    m_arr_valid = 1'b0;
    m_arr_addr  = '0;
  endtask

  // Compare all outputs against the model, log traffic, then advance the
  // model across the coming edge using the inputs seen this cycle.
  task automatic model_step();
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [3:0]  e_be;
    cyc++;
    e_valid = (mq.size() > 0) && !i_redirect;
    e_pc    = (mq.size() > 0) ? mq[0].pc  : 32'h0;
    e_ins   = (mq.size() > 0) ? mq[0].ins : 32'h0;
    e_be    = m_rd ? 4'hF : 4'h0;

    n_checks++;
    if (o_pc_rd !== m_rd) begin
      n_fail++; $display("FAIL cyc=%0d model o_pc_rd got=%b exp=%b", cyc, o_pc_rd, m_rd);
    end
    n_checks++;
    if (o_pc_addr !== m_addr) begin
      n_fail++; $display("FAIL cyc=%0d model o_pc_addr got=%h exp=%h", cyc, o_pc_addr, m_addr);
    end
    n_checks++;
    if (o_pc_byte_en !== e_be) begin
      n_fail++; $display("FAIL cyc=%0d model o_pc_byte_en got=%h exp=%h", cyc, o_pc_byte_en, e_be);
    end
    n_checks++;
    if (o_ins_valid !== e_valid) begin
      n_fail++; $display("FAIL cyc=%0d model o_ins_valid got=%b exp=%b", cyc, o_ins_valid, e_valid);
    end
    n_checks++;
    if (o_ins_pc !== e_pc || o_ins !== e_ins) begin
      n_fail++; $display("FAIL cyc=%0d model head got=%h/%h exp=%h/%h", cyc, o_ins_pc, o_ins, e_pc, e_ins);
    end

    if (o_ins_valid === 1'b1 && i_ins_ready === 1'b1) begin
      deliv_pc.push_back(o_ins_pc);
      deliv_cyc.push_back(cyc);
    end
    if (o_pc_rd === 1'b1) issue_addr.push_back(o_pc_addr);

    if (reset) begin
      model_reset();
    end else if (i_redirect) begin
      mq.delete();
      m_arr_valid = 1'b0;             // read issued now belongs to old path
      m_rd        = 1'b1;
      m_addr      = word_align(i_redirect_pc);
      m_next_pc   = m_addr + 32'd4;
    end else begin
      if (e_valid && i_ins_ready) void'(mq.pop_front());
      if (m_arr_valid) mq.push_back('{pc: m_arr_addr, ins: mem_word(m_arr_addr)});
      m_arr_valid = m_rd;
      m_arr_addr  = m_addr;
      if (mq.size() + int'(m_rd) + 1 <= DEPTH) begin
        m_rd      = 1'b1;
        m_addr    = m_next_pc;
        m_next_pc = m_next_pc + 32'd4;
      end else begin
        m_rd = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    deliv_pc.delete();
    deliv_cyc.delete();
    issue_addr.delete();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; i_ins_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if ({o_pc_rd, o_pc_byte_en, o_pc_addr} !== {1'b0, 4'h0, RESET_PC}) begin
      n_fail++; $display("FAIL reset_issue got rd=%b be=%h addr=%h exp rd=0 be=0 addr=%h",
                         o_pc_rd, o_pc_byte_en, o_pc_addr, RESET_PC);
    end
    n_checks++;
    if ({o_ins_valid, o_ins, o_ins_pc} !== {1'b0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_head got valid=%b ins=%h pc=%h exp 0/0/0", o_ins_valid, o_ins, o_ins_pc);
    end
    tick();
  endtask

  task automatic test_stream();
    i_ins_ready = 1'b1;
    reset       = 1'b0;
    tick();
    n_checks++;
    if ({o_pc_rd, o_pc_addr, o_ins_valid} !== {1'b1, RESET_PC, 1'b0}) begin
      n_fail++; $display("FAIL stream_first_rd got rd=%b addr=%h valid=%b exp 1/%h/0", o_pc_rd, o_pc_addr, o_ins_valid, RESET_PC);
    end
    tick();
    n_checks++;
    if ({o_pc_rd, o_pc_addr, o_ins_valid} !== {1'b1, 32'h4, 1'b0}) begin
      n_fail++; $display("FAIL stream_second_rd got rd=%b addr=%h valid=%b exp 1/4/0", o_pc_rd, o_pc_addr, o_ins_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({o_ins_valid, o_ins_pc, o_ins} !== {1'b1, 32'(4 * i), 32'(4 * i)}) begin
        n_fail++; $display("FAIL stream_deliver%0d got valid=%b pc=%h ins=%h exp pc=ins=%h",
                           i, o_ins_valid, o_ins_pc, o_ins, 32'(4 * i));
      end
    end
    repeat (6) tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] got4;
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    i_ins_ready = 1'b0;
    clear_logs();
    repeat (8) tick();
    got4 = '0;
    for (int i = 0; i < issue_addr.size() && i < 4; i++) got4[32*i +: 32] = issue_addr[i];
    n_checks++;
    if (issue_addr.size() != 4 || got4 !== {32'd12, 32'd8, 32'd4, 32'd0}) begin
      n_fail++; $display("FAIL bp_reads got count=%0d addrs=%h exp count=4 addrs 0,4,8,12", issue_addr.size(), got4);
    end
    n_checks++;
    if ({o_pc_rd, o_ins_valid, o_ins_pc} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL bp_full got rd=%b valid=%b pc=%h exp 0/1/0", o_pc_rd, o_ins_valid, o_ins_pc);
    end
    clear_logs();
    i_ins_ready = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (deliv_pc.size() < 5) begin
      n_fail++; $display("FAIL bp_release_count got=%0d exp>=5", deliv_pc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (deliv_pc[i] !== 32'(4 * i)) begin
          n_fail++; $display("FAIL bp_order%0d got=%h exp=%h", i, deliv_pc[i], 32'(4 * i));
        end
      end
      n_checks++;
      if (deliv_cyc[4] - deliv_cyc[0] != 4) begin
        n_fail++; $display("FAIL bp_gapless got span=%0d exp=4", deliv_cyc[4] - deliv_cyc[0]);
      end
    end
    n_checks++;
    if (issue_addr.size() == 0 || issue_addr[0] !== 32'd16) begin
      n_fail++; $display("FAIL bp_resume got n=%0d first=%h exp first=10", issue_addr.size(),
                         (issue_addr.size() != 0) ? issue_addr[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_flush();
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    i_ins_ready = 1'b0;
    repeat (5) tick();  // three entries queued, response for 12 arriving
    n_checks++;
    if ({o_ins_valid, o_pc_rd} !== 2'b10) begin
      n_fail++; $display("FAIL rf_setup got valid=%b rd=%b exp 1/0", o_ins_valid, o_pc_rd);
    end
    clear_logs();
    i_redirect = 1'b1; i_redirect_pc = 32'h100; i_ins_ready = 1'b1;
    #1;
    n_checks++;
    if (o_ins_valid !== 1'b0) begin
      n_fail++; $display("FAIL rf_hide_head got=%b exp=0", o_ins_valid);
    end
    tick();
    i_redirect = 1'b0;
    n_checks++;
    if ({o_pc_rd, o_pc_addr, o_ins_valid} !== {1'b1, 32'h100, 1'b0}) begin
      n_fail++; $display("FAIL rf_target got rd=%b addr=%h valid=%b exp 1/100/0", o_pc_rd, o_pc_addr, o_ins_valid);
    end
    repeat (6) tick();
    n_checks++;
    if (deliv_pc.size() < 2 || deliv_pc[0] !== 32'h100 || deliv_pc[1] !== 32'h104) begin
      n_fail++; $display("FAIL rf_first_deliv got n=%0d first=%h exp 100,104", deliv_pc.size(),
                         (deliv_pc.size() != 0) ? deliv_pc[0] : 32'hx);
    end
    foreach (deliv_pc[i]) begin
      n_checks++;
      if (deliv_pc[i] < 32'h100) begin
        n_fail++; $display("FAIL rf_stale_pc got=%h exp>=100", deliv_pc[i]);
      end
    end
  endtask

  task automatic test_redirect_unaligned();
    i_ins_ready = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({o_ins_valid, o_pc_rd} !== 2'b11) begin
      n_fail++; $display("FAIL ru_setup got valid=%b rd=%b exp 1/1", o_ins_valid, o_pc_rd);
    end
    clear_logs();
    i_redirect = 1'b1; i_redirect_pc = 32'h103;
    #1;
    n_checks++;
    if (o_ins_valid !== 1'b0) begin
      n_fail++; $display("FAIL ru_hide_head got=%b exp=0", o_ins_valid);
    end
    tick();
    i_redirect = 1'b0;
    n_checks++;
    if ({o_pc_rd, o_pc_addr} !== {1'b1, 32'h100}) begin
      n_fail++; $display("FAIL ru_aligned got rd=%b addr=%h exp 1/100", o_pc_rd, o_pc_addr);
    end
    repeat (6) tick();
    n_checks++;
    if (deliv_pc.size() < 2 || deliv_pc[0] !== 32'h100 || deliv_pc[1] !== 32'h104) begin
      n_fail++; $display("FAIL ru_first_deliv got n=%0d first=%h exp 100,104", deliv_pc.size(),
                         (deliv_pc.size() != 0) ? deliv_pc[0] : 32'hx);
    end
  endtask

  task automatic test_reset_full();
    i_ins_ready = 1'b0;
    repeat (8) tick();
    n_checks++;
    if ({o_pc_rd, o_ins_valid} !== 2'b01) begin
      n_fail++; $display("FAIL rst_full_setup got rd=%b valid=%b exp 0/1", o_pc_rd, o_ins_valid);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({o_ins_valid, o_pc_rd, o_pc_addr} !== {1'b0, 1'b0, RESET_PC}) begin
      n_fail++; $display("FAIL rst_full_clear got valid=%b rd=%b addr=%h exp 0/0/%h", o_ins_valid, o_pc_rd, o_pc_addr, RESET_PC);
    end
    reset       = 1'b0;
    i_ins_ready = 1'b1;
    clear_logs();
    tick();
    n_checks++;
    if ({o_pc_rd, o_pc_addr} !== {1'b1, RESET_PC}) begin
      n_fail++; $display("FAIL rst_full_restart got rd=%b addr=%h exp 1/%h", o_pc_rd, o_pc_addr, RESET_PC);
    end
    repeat (4) tick();
    n_checks++;
    if (deliv_pc.size() == 0 || deliv_pc[0] !== RESET_PC) begin
      n_fail++; $display("FAIL rst_full_deliv got n=%0d first=%h exp %h", deliv_pc.size(),
                         (deliv_pc.size() != 0) ? deliv_pc[0] : 32'hx, RESET_PC);
    end
  endtask

  task automatic test_random();
    mem_xor   = $urandom;
    idle_rand = 1'b1;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 800; i++) begin
      i_ins_ready   = ($urandom_range(0, 9) < 7);
      i_redirect    = ($urandom_range(0, 15) == 0);
      i_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
      reset         = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; i_redirect = 1'b0; i_ins_ready = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    reset = 1'b1; i_ins_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_pc_rddata = RV_NOP;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_unaligned();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
